// File: rtl/calendar_date_counter_pkg.sv
// Shared widths, month indices, adjust-field encodings and FSM states for the
// calendar date counter.
package calendar_date_counter_pkg;

    // Field widths
    localparam int unsigned YEAR_W = 7;
    localparam int unsigned MON_W  = 4;
    localparam int unsigned DAY_W  = 5;

    // Month indices (0-based)
    localparam logic [MON_W-1:0] JAN = 4'd0;
    localparam logic [MON_W-1:0] FEB = 4'd1;
    localparam logic [MON_W-1:0] MAR = 4'd2;
    localparam logic [MON_W-1:0] APR = 4'd3;
    localparam logic [MON_W-1:0] MAY = 4'd4;
    localparam logic [MON_W-1:0] JUN = 4'd5;
    localparam logic [MON_W-1:0] JUL = 4'd6;
    localparam logic [MON_W-1:0] AUG = 4'd7;
    localparam logic [MON_W-1:0] SEP = 4'd8;
    localparam logic [MON_W-1:0] OCT = 4'd9;
    localparam logic [MON_W-1:0] NOV = 4'd10;
    localparam logic [MON_W-1:0] DEC = 4'd11;

    // Adjust field select
    localparam logic [1:0] SEL_DAY  = 2'd0;
    localparam logic [1:0] SEL_MON  = 2'd1;
    localparam logic [1:0] SEL_YEAR = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    // Controller states; StFix is the one-cycle day clamp after a field change
    typedef enum logic {
        StIdle = 1'b0,
        StFix  = 1'b1
    } state_e;

    // Smaller of two day indices
    function automatic logic [DAY_W-1:0] day_min(input logic [DAY_W-1:0] a,
                                                 input logic [DAY_W-1:0] b);
        return (a > b) ? b : a;
    endfunction

endpackage

// File: rtl/month_day_limit.sv
// Last-day index of a month, given the year index and month index.
module month_day_limit
    import calendar_date_counter_pkg::*;
(
    input  logic [YEAR_W-1:0] year,
    input  logic [MON_W-1:0]  mon,
    output logic [DAY_W-1:0]  day_max
);

    logic leap;

    // Year 0 is treated as a non-leap year
    assign leap = (year != '0) && (year[1:0] == 2'b00);

    // Month-length lookup; out-of-range months report the long-month limit
    always_comb begin
        day_max = 5'd30;
        case (mon)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: day_max = 5'd30;
            APR, JUN, SEP, NOV:               day_max = 5'd29;
            FEB:                              day_max = leap ? 5'd28 : 5'd27;
            default:                          day_max = 5'd30;
        endcase
    end

endmodule

// File: rtl/calendar_date_counter.sv
// Year/month/day calendar counter. Advances one day per tick, supports a full
// load and per-field adjust; month/year changes pass through a one-cycle clamp
// state that pulls the day back inside the new month.
module calendar_date_counter
    import calendar_date_counter_pkg::*;
#(
    parameter int unsigned YEAR_MAX = 99,
    parameter int unsigned MON_LAST = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              load,
    input  logic [YEAR_W-1:0] ld_year,
    input  logic [MON_W-1:0]  ld_mon,
    input  logic [DAY_W-1:0]  ld_day,
    input  logic              adj_en,
    input  logic [1:0]        adj_sel,
    input  logic              adj_up,
    output logic [YEAR_W-1:0] year,
    output logic [MON_W-1:0]  mon,
    output logic [DAY_W-1:0]  day,
    output logic [DAY_W-1:0]  day_max,
    output logic              new_month,
    output logic              new_year,
    output logic              busy
);

    localparam logic [YEAR_W-1:0] YearMax = YEAR_W'(YEAR_MAX);
    localparam logic [MON_W-1:0]  MonLast = MON_W'(MON_LAST);

    logic [YEAR_W-1:0] year_q;
    logic [MON_W-1:0]  mon_q;
    logic [DAY_W-1:0]  day_q;
    logic              new_month_q;
    logic              new_year_q;
    logic              tick_pend_q;
    state_e            state_q;

    logic [DAY_W-1:0]  day_max_w;
    logic [DAY_W-1:0]  day_clamp;

    // Adjust candidates
    logic [DAY_W-1:0]  day_up;
    logic [DAY_W-1:0]  day_dn;
    logic [MON_W-1:0]  mon_up;
    logic [MON_W-1:0]  mon_dn;
    logic [YEAR_W-1:0] year_up;
    logic [YEAR_W-1:0] year_dn;

    // Load candidates, saturated to the field range
    logic [YEAR_W-1:0] ld_year_sat;
    logic [MON_W-1:0]  ld_mon_sat;

    // Tick-advance candidates
    logic              day_wrap;
    logic              mon_wrap;
    logic [MON_W-1:0]  mon_next;
    logic [YEAR_W-1:0] year_next;

    month_day_limit u_month_day_limit (
        .year    (year_q),
        .mon     (mon_q),
        .day_max (day_max_w)
    );

    // In IDLE day never exceeds day_max, so the clamp is transparent there;
    // in FIX it supplies the corrected day for both the fix and a day adjust.
    assign day_clamp = day_min(day_q, day_max_w);

    // Candidate next values for adjust, load and tick advance
    always_comb begin
        day_up      = (day_clamp >= day_max_w) ? '0 : day_clamp + 5'd1;
        day_dn      = (day_clamp == '0) ? day_max_w : day_clamp - 5'd1;
        mon_up      = (mon_q >= MonLast) ? '0 : mon_q + 4'd1;
        mon_dn      = (mon_q == '0) ? MonLast : mon_q - 4'd1;
        year_up     = (year_q >= YearMax) ? '0 : year_q + 7'd1;
        year_dn     = (year_q == '0) ? YearMax : year_q - 7'd1;

        ld_year_sat = (ld_year > YearMax) ? YearMax : ld_year;
        ld_mon_sat  = (ld_mon > MonLast) ? MonLast : ld_mon;

        day_wrap    = (day_q >= day_max_w);
        mon_wrap    = (mon_q >= MonLast);
        mon_next    = mon_wrap ? '0 : mon_q + 4'd1;
        year_next   = year_up;
    end

    // Controller: priority rst > load > adjust > fix > tick/pending advance
    always_ff @(posedge clk) begin
        if (rst) begin
            year_q      <= '0;
            mon_q       <= '0;
            day_q       <= '0;
            new_month_q <= 1'b0;
            new_year_q  <= 1'b0;
            tick_pend_q <= 1'b0;
            state_q     <= StIdle;
        end else begin
            new_month_q <= 1'b0;
            new_year_q  <= 1'b0;
            if (load) begin
                // Tick coinciding with a load is deliberately dropped
                year_q      <= ld_year_sat;
                mon_q       <= ld_mon_sat;
                day_q       <= ld_day;
                tick_pend_q <= 1'b0;
                state_q     <= StFix;
            end else if (adj_en) begin
                // Any tick arriving with an adjust is held for later
                if (tick) begin
                    tick_pend_q <= 1'b1;
                end
                case (adj_sel)
                    SEL_DAY: begin
                        day_q   <= adj_up ? day_up : day_dn;
                        state_q <= StIdle;
                    end
                    SEL_MON: begin
                        mon_q   <= adj_up ? mon_up : mon_dn;
                        state_q <= StFix;
                    end
                    SEL_YEAR: begin
                        year_q  <= adj_up ? year_up : year_dn;
                        state_q <= StFix;
                    end
                    default: begin
                        // No field change; still finish a pending clamp
                        day_q   <= day_clamp;
                        state_q <= StIdle;
                    end
                endcase
            end else if (state_q == StFix) begin
                day_q   <= day_clamp;
                state_q <= StIdle;
                if (tick) begin
                    tick_pend_q <= 1'b1;
                end
            end else if (tick || tick_pend_q) begin
                // One advance per cycle; a coincident tick keeps the pending bit
                tick_pend_q <= tick && tick_pend_q;
                if (!day_wrap) begin
                    day_q <= day_q + 5'd1;
                end else begin
                    day_q       <= '0;
                    new_month_q <= 1'b1;
                    mon_q       <= mon_next;
                    if (mon_wrap) begin
                        new_year_q <= 1'b1;
                        year_q     <= year_next;
                    end
                end
            end
        end
    end

    // Output mapping
    assign year      = year_q;
    assign mon       = mon_q;
    assign day       = day_q;
    assign day_max   = day_max_w;
    assign new_month = new_month_q;
    assign new_year  = new_year_q;
    assign busy      = (state_q == StFix);

endmodule

// File: tb/tb_calendar_date_counter.sv
// Self-checking bench for calendar_date_counter: directed calendar scenarios
// followed by randomized traffic, all checked against a date model built from
// month lengths and modular field arithmetic.
module tb_calendar_date_counter;

    localparam int YMAX = 99;
    localparam int MLAST = 11;
    localparam int MonthLen [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [6:0] ld_year = '0;
    logic [3:0] ld_mon = '0;
    logic [4:0] ld_day = '0;
    logic       adj_en = 1'b0;
    logic [1:0] adj_sel = '0;
    logic       adj_up = 1'b0;
    logic [6:0] year;
    logic [3:0] mon;
    logic [4:0] day;
    logic [4:0] day_max;
    logic       new_month;
    logic       new_year;
    logic       busy;

    always #5 clk = ~clk;

    calendar_date_counter #(
        .YEAR_MAX (99),
        .MON_LAST (11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .load      (load),
        .ld_year   (ld_year),
        .ld_mon    (ld_mon),
        .ld_day    (ld_day),
        .adj_en    (adj_en),
        .adj_sel   (adj_sel),
        .adj_up    (adj_up),
        .year      (year),
        .mon       (mon),
        .day       (day),
        .day_max   (day_max),
        .new_month (new_month),
        .new_year  (new_year),
        .busy      (busy)
    );

    int total = 0;
    int bad = 0;

    // Reference date state
    int m_year = 0;
    int m_mon = 0;
    int m_day = 0;
    bit m_nm = 0;
    bit m_ny = 0;
    bit m_pend = 0;
    bit m_fix = 0;

    function automatic int last_idx(input int y, input int m);
        int len;
        if (m > MLAST) return 30;
        len = MonthLen[m];
        if (m == 1 && (y % 4) == 0 && y != 0) len = 29;
        return len - 1;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Next-day rule on the model date
    function automatic void model_advance();
        if (m_day < last_idx(m_year, m_mon)) begin
            m_day = m_day + 1;
        end else begin
            m_day = 0;
            m_nm = 1;
            if (m_mon < MLAST) begin
                m_mon = m_mon + 1;
            end else begin
                m_mon = 0;
                m_ny = 1;
                m_year = (m_year + 1) % (YMAX + 1);
            end
        end
    endfunction

    // One clock of the reference, using the inputs presented for this edge
    function automatic void model_step();
        int dm;
        int base;
        dm = last_idx(m_year, m_mon);
        m_nm = 0;
        m_ny = 0;
        if (rst) begin
            m_year = 0; m_mon = 0; m_day = 0; m_pend = 0; m_fix = 0;
        end else if (load) begin
            m_year = imin(int'(ld_year), YMAX);
            m_mon = imin(int'(ld_mon), MLAST);
            m_day = int'(ld_day);
            m_pend = 0;
            m_fix = 1;
        end else if (adj_en) begin
            if (tick) m_pend = 1;
            base = imin(m_day, dm);
            case (int'(adj_sel))
                0: begin
                    m_day = adj_up ? (base + 1) % (dm + 1) : (base + dm) % (dm + 1);
                    m_fix = 0;
                end
                1: begin
                    m_mon = adj_up ? (m_mon + 1) % (MLAST + 1) : (m_mon + MLAST) % (MLAST + 1);
                    m_fix = 1;
                end
                2: begin
                    m_year = adj_up ? (m_year + 1) % (YMAX + 1) : (m_year + YMAX) % (YMAX + 1);
                    m_fix = 1;
                end
                default: begin
                    m_day = base;
                    m_fix = 0;
                end
            endcase
        end else if (m_fix) begin
            m_day = imin(m_day, dm);
            m_fix = 0;
            if (tick) m_pend = 1;
        end else if (tick || m_pend) begin
            m_pend = tick && m_pend;
            model_advance();
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("year", 32'(year), 32'(m_year));
        chk("mon", 32'(mon), 32'(m_mon));
        chk("day", 32'(day), 32'(m_day));
        chk("day_max", 32'(day_max), 32'(last_idx(m_year, m_mon)));
        chk("new_month", 32'(new_month), 32'(m_nm));
        chk("new_year", 32'(new_year), 32'(m_ny));
        chk("busy", 32'(busy), 32'(m_fix));
    endtask

    // Drive one cycle of inputs at the falling edge, step the model on the
    // rising edge, compare shortly after it.
    task automatic cyc(input bit r, input bit t, input bit l, input int ly, input int lm,
                       input int ld, input bit ae, input int as, input bit au);
        @(negedge clk);
        rst = r;
        tick = t;
        load = l;
        ld_year = 7'(ly);
        ld_mon = 4'(lm);
        ld_day = 5'(ld);
        adj_en = ae;
        adj_sel = 2'(as);
        adj_up = au;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_tick();
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_load(input int y, input int m, input int d);
        cyc(0, 0, 1, y, m, d, 0, 0, 0);
    endtask

    task automatic do_adj(input int sel, input bit up, input bit t);
        cyc(0, t, 0, 0, 0, 0, 1, sel, up);
    endtask

    int p, ly, lm, ld, as;
    bit r, t, l, ae, au;

    initial begin
        // Reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_year", 32'(year), 0);
        chk("rst_day", 32'(day), 0);
        chk("rst_busy", 32'(busy), 0);

        // January runs to day 30, then rolls into February
        for (int i = 0; i < 30; i++) do_tick();
        chk("jan_last_day", 32'(day), 30);
        do_tick();
        chk("feb_first_day", 32'(day), 0);
        chk("feb_first_mon", 32'(mon), 1);
        chk("feb_new_month", 32'(new_month), 1);
        chk("feb_new_year", 32'(new_year), 0);
        do_idle();
        chk("new_month_clear", 32'(new_month), 0);

        // Leap February in year 4
        do_load(4, 1, 27);
        do_idle();
        do_tick();
        chk("leap_feb28", 32'(day), 28);
        do_tick();
        chk("leap_mar_day", 32'(day), 0);
        chk("leap_mar_mon", 32'(mon), 2);

        // Year 0 is not a leap year
        do_load(0, 1, 27);
        do_idle();
        do_tick();
        chk("y0_mar_day", 32'(day), 0);
        chk("y0_mar_mon", 32'(mon), 2);

        // Last day of the last year wraps everything
        do_load(99, 11, 30);
        do_idle();
        do_tick();
        chk("wrap_year", 32'(year), 0);
        chk("wrap_mon", 32'(mon), 0);
        chk("wrap_nm", 32'(new_month), 1);
        chk("wrap_ny", 32'(new_year), 1);

        // Month adjust forces a clamp; a tick during the clamp is kept
        do_load(5, 0, 30);
        do_idle();
        do_adj(1, 1, 0);
        chk("adj_mon", 32'(mon), 1);
        chk("adj_busy", 32'(busy), 1);
        do_tick();
        chk("clamp_day", 32'(day), 27);
        do_idle();
        chk("pend_day", 32'(day), 0);
        chk("pend_mon", 32'(mon), 2);
        chk("pend_nm", 32'(new_month), 1);

        // Day adjust down wraps to the month's last day
        do_load(0, 3, 0);
        do_idle();
        do_adj(0, 0, 0);
        chk("dadj_day", 32'(day), 29);
        chk("dadj_busy", 32'(busy), 0);
        chk("dadj_nm", 32'(new_month), 0);

        // Out-of-range load saturates, then clamps day
        do_load(120, 14, 31);
        chk("sat_year", 32'(year), 99);
        chk("sat_mon", 32'(mon), 11);
        do_idle();
        chk("sat_day", 32'(day), 30);
        do_load(7, 1, 31);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("midfix_rst_day", 32'(day), 0);
        chk("midfix_rst_busy", 32'(busy), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            p = $urandom_range(0, 99);
            r = 0; t = 0; l = 0; ae = 0; au = 0;
            ly = 0; lm = 0; ld = 0; as = 0;
            if (p < 1) begin
                r = 1;
            end else if (p < 8) begin
                l = 1;
                ly = $urandom_range(0, 127);
                lm = $urandom_range(0, 15);
                ld = $urandom_range(0, 31);
            end else if (p < 25) begin
                ae = 1;
                as = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
                au = 1'($urandom_range(0, 1));
            end
            t = ($urandom_range(0, 99) < 65);
            // Only one tick can be held back at a time
            if (m_pend && (ae || m_fix)) t = 0;
            cyc(r, t, l, ly, lm, ld, ae, as, au);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
